stream2fifo_native: RTL

STREAM2FIFO_NATIVE -- requirements
Module: stream2fifo_native

---
 rtl/stream2fifo_native.sv | 110 +++++++++++
 1 files changed

// File: rtl/stream2fifo_native.sv
// AXI-Stream slave to native FIFO write port through a 2-entry skid buffer.
// Tracks beats and packets written to the FIFO.
//
// state  | meaning
// OCC_0  | buffer empty, din don't-care, no write
// OCC_1  | one beat held in ent0
// OCC_2  | two beats held (ent0 oldest), upstream stalled
module stream2fifo_native #(
    parameter int DATA_WIDTH = 256,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tlast,
    input  logic                  full,
    output logic                  wr_en,
    output logic [DATA_WIDTH:0]   din,
    output logic [CNT_WIDTH-1:0]  beat_cnt,
    output logic [CNT_WIDTH-1:0]  pkt_cnt
);

    typedef enum logic [1:0] {
        OCC_0 = 2'd0,
        OCC_1 = 2'd1,
        OCC_2 = 2'd2
    } occ_t;

    occ_t                state;
    occ_t                state_nxt;
    logic                ready_en;
    logic [DATA_WIDTH:0] ent0;
    logic [DATA_WIDTH:0] ent1;
    logic [DATA_WIDTH:0] ent0_nxt;
    logic [DATA_WIDTH:0] ent1_nxt;
    logic [DATA_WIDTH:0] beat_in;
    logic                accept;
    logic                pop;

    // tready depends only on registers, so the upstream sees no path from full
    assign s_axis_tready = ready_en && (state != OCC_2);
    assign wr_en         = (state != OCC_0) && !full;
    assign accept        = s_axis_tvalid && s_axis_tready;
    assign pop           = wr_en;
    assign beat_in       = {s_axis_tlast, s_axis_tdata};
    assign din           = ent0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= OCC_0;
            ready_en <= 1'b0;
            ent0     <= '0;
            ent1     <= '0;
        end else begin
            state    <= state_nxt;
            ready_en <= 1'b1;
            ent0     <= ent0_nxt;
            ent1     <= ent1_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ent0_nxt  = ent0;
        ent1_nxt  = ent1;
        case (state)
            OCC_0: begin
                if (accept) begin
                    ent0_nxt  = beat_in;
                    state_nxt = OCC_1;
                end
            end
            OCC_1: begin
                if (accept && pop) begin
                    ent0_nxt = beat_in;
                end else if (accept) begin
                    ent1_nxt  = beat_in;
                    state_nxt = OCC_2;
                end else if (pop) begin
                    state_nxt = OCC_0;
                end
            end
            OCC_2: begin
                // no accept possible here, tready is low
                if (pop) begin
                    ent0_nxt  = ent1;
                    state_nxt = OCC_1;
                end
            end
            default: begin
                state_nxt = OCC_0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt <= '0;
            pkt_cnt  <= '0;
        end else if (pop) begin
            beat_cnt <= beat_cnt + CNT_WIDTH'(1);
            if (ent0[DATA_WIDTH]) begin
                pkt_cnt <= pkt_cnt + CNT_WIDTH'(1);
            end
        end
    end

endmodule
